dispatch_unit: RTL

In-order dispatch stage that feeds the reservation station. Holds the architectural register file plus a per-register rename tag/busy table. Converts each decoded instruction into an RS entry: opcode, PC, destination tag, source tags, source data and per-operand valid bits. Snoops the ALU result broadcast and uses credits to never overflow the 16-entry station.

---
 rtl/dispatch_pkg.sv | 34 +++
 rtl/dispatch_unit_rename_table.sv | 117 +++++++++++
 rtl/dispatch_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/dispatch_pkg.sv
// Shared types and constants for the dispatch stage and its rename table.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional feature macro: DISPATCH_CDB_BYPASS_EN.
package dispatch_pkg;

   localparam int TAG_W     = 7;
   localparam int DATA_W    = 32;
   localparam int PC_W      = 32;
   localparam int OPC_W     = 7;
   localparam int REG_IDX_W = 5;
   localparam int NUM_REGS  = 32;

   // Tag 0 means "no producer"; live tags run TAG_FIRST..TAG_LAST and wrap.
   localparam logic [TAG_W-1:0] NO_TAG    = '0;
   localparam logic [TAG_W-1:0] TAG_FIRST = 7'd1;
   localparam logic [TAG_W-1:0] TAG_LAST  = 7'd127;

   typedef struct packed {
      logic [OPC_W-1:0]  opcode;
      logic [PC_W-1:0]   pc;
      logic [TAG_W-1:0]  rd_tag;
      logic [TAG_W-1:0]  op1_tag;
      logic [TAG_W-1:0]  op2_tag;
      logic [DATA_W-1:0] op1_dat;
      logic [DATA_W-1:0] op2_dat;
      logic [1:0]        valid;
   } rs_pkt_t;

   // Advance the tag allocator, skipping NO_TAG on wrap.
   function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] t);
      return (t == TAG_LAST) ? TAG_FIRST : t + TAG_W'(1);
   endfunction

endpackage

// File: rtl/dispatch_unit_rename_table.sv
// Register file plus per-register busy/tag table with two lookup ports.
// Latency: lookups combinational; rename and broadcast writes land at the next edge.
// Backpressure: none; snoop_stall_o flags a same-cycle broadcast hit (0 with DISPATCH_CDB_BYPASS_EN).
module rename_table
   import dispatch_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [REG_IDX_W-1:0] rd_idx_a_i,
   input  logic [REG_IDX_W-1:0] rd_idx_b_i,
   output logic                 rd_vld_a_o,
   output logic [TAG_W-1:0]     rd_tag_a_o,
   output logic [DATA_W-1:0]    rd_dat_a_o,
   output logic                 rd_vld_b_o,
   output logic [TAG_W-1:0]     rd_tag_b_o,
   output logic [DATA_W-1:0]    rd_dat_b_o,
   output logic                 snoop_stall_o,
   input  logic                 ren_en_i,
   input  logic [REG_IDX_W-1:0] ren_idx_i,
   input  logic [TAG_W-1:0]     ren_tag_i,
   input  logic                 bc_vld_i,
   input  logic [TAG_W-1:0]     bc_tag_i,
   input  logic [DATA_W-1:0]    bc_dat_i
);

   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic [TAG_W-1:0]    tag_q [NUM_REGS];
   logic [TAG_W-1:0]    tag_d [NUM_REGS];
   logic [DATA_W-1:0]   dat_q [NUM_REGS];
   logic [DATA_W-1:0]   dat_d [NUM_REGS];

   logic [REG_IDX_W-1:0] rd_idx [2];
   logic                 rd_vld [2];
   logic [TAG_W-1:0]     rd_tag [2];
   logic [DATA_W-1:0]    rd_dat [2];
   logic                 rd_hit [2];

   assign rd_idx[0] = rd_idx_a_i;
   assign rd_idx[1] = rd_idx_b_i;

   // Source lookup against pre-update contents; r0 always reads as a valid zero.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_vld[p] = 1'b1;
         rd_tag[p] = NO_TAG;
         rd_dat[p] = '0;
         rd_hit[p] = 1'b0;
         if (rd_idx[p] != '0) begin
            if (busy_q[rd_idx[p]]) begin
               rd_hit[p] = bc_vld_i && (tag_q[rd_idx[p]] == bc_tag_i);
`ifdef DISPATCH_CDB_BYPASS_EN
               if (rd_hit[p]) begin
                  rd_dat[p] = bc_dat_i;
               end else begin
                  rd_vld[p] = 1'b0;
                  rd_tag[p] = tag_q[rd_idx[p]];
               end
`else
               rd_vld[p] = 1'b0;
               rd_tag[p] = tag_q[rd_idx[p]];
`endif
            end else begin
               rd_dat[p] = dat_q[rd_idx[p]];
            end
         end
      end
   end

   assign rd_vld_a_o = rd_vld[0];
   assign rd_tag_a_o = rd_tag[0];
   assign rd_dat_a_o = rd_dat[0];
   assign rd_vld_b_o = rd_vld[1];
   assign rd_tag_b_o = rd_tag[1];
   assign rd_dat_b_o = rd_dat[1];

`ifdef DISPATCH_CDB_BYPASS_EN
   assign snoop_stall_o = 1'b0;
`else
   // Without the bypass, a lookup racing its own producer's broadcast must retry.
   assign snoop_stall_o = rd_hit[0] | rd_hit[1];
`endif

   // Broadcast writes data and clears busy; a same-cycle rename then overrides the clear.
   always_comb begin
      busy_d = busy_q;
      tag_d  = tag_q;
      dat_d  = dat_q;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (bc_vld_i && busy_q[i] && (tag_q[i] == bc_tag_i)) begin
            dat_d[i]  = bc_dat_i;
            busy_d[i] = 1'b0;
         end
      end
      if (ren_en_i && (ren_idx_i != '0)) begin
         busy_d[ren_idx_i] = 1'b1;
         tag_d[ren_idx_i]  = ren_tag_i;
      end
   end

   // Table state register with synchronous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            tag_q[i] <= NO_TAG;
            dat_q[i] <= '0;
         end
      end else begin
         busy_q <= busy_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            tag_q[i] <= tag_d[i];
            dat_q[i] <= dat_d[i];
         end
      end
   end

endmodule

// File: rtl/dispatch_unit.sv
// In-order dispatch: renames sources/destination and emits one RS packet per accepted instruction.
// Latency: accept in cycle T -> rs_dispatch strobe in cycle T+1.
// Backpressure: credit based (RS_DEPTH); inst_ready also drops on a broadcast race unless DISPATCH_CDB_BYPASS_EN.
module dispatch_unit
   import dispatch_pkg::*;
#(
   parameter int RS_DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 inst_valid,
   output logic                 inst_ready,
   input  logic [OPC_W-1:0]     opcode,
   input  logic [PC_W-1:0]      PC,
   input  logic [REG_IDX_W-1:0] rd,
   input  logic [REG_IDX_W-1:0] rs1,
   input  logic [REG_IDX_W-1:0] rs2,
   output logic                 rs_dispatch,
   output logic [OPC_W-1:0]     rs_opcode,
   output logic [PC_W-1:0]      rs_PC,
   output logic [TAG_W-1:0]     rs_Rd,
   output logic [TAG_W-1:0]     rs_operand1,
   output logic [TAG_W-1:0]     rs_operand2,
   output logic [DATA_W-1:0]    rs_operand1_data,
   output logic [DATA_W-1:0]    rs_operand2_data,
   output logic [1:0]           rs_valid,
   input  logic                 rs_issue,
   input  logic [DATA_W-1:0]    ALU_result,
   input  logic [TAG_W-1:0]     ALU_result_dest,
   input  logic                 ALU_result_valid
);

   localparam int CRED_W = $clog2(RS_DEPTH + 1);

   logic [CRED_W-1:0] credits_q, credits_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic              disp_q, disp_d;
   rs_pkt_t           pkt_q, pkt_d, pkt_out;

   logic              accept;
   logic              snoop_stall;
   logic              src1_vld, src2_vld;
   logic [TAG_W-1:0]  src1_tag, src2_tag;
   logic [DATA_W-1:0] src1_dat, src2_dat;

   rename_table u_rename_table (
      .clk           (clk),
      .reset         (reset),
      .rd_idx_a_i    (rs1),
      .rd_idx_b_i    (rs2),
      .rd_vld_a_o    (src1_vld),
      .rd_tag_a_o    (src1_tag),
      .rd_dat_a_o    (src1_dat),
      .rd_vld_b_o    (src2_vld),
      .rd_tag_b_o    (src2_tag),
      .rd_dat_b_o    (src2_dat),
      .snoop_stall_o (snoop_stall),
      .ren_en_i      (accept),
      .ren_idx_i     (rd),
      .ren_tag_i     (tag_q),
      .bc_vld_i      (ALU_result_valid),
      .bc_tag_i      (ALU_result_dest),
      .bc_dat_i      (ALU_result)
   );

   assign inst_ready = (credits_q != '0) && !snoop_stall;
   assign accept     = inst_valid && inst_ready;

   // Credit, tag-allocator and output-stage next state.
   always_comb begin
      credits_d = credits_q;
      tag_d     = tag_q;
      disp_d    = accept;
      pkt_d     = pkt_q;
      unique case ({rs_issue, accept})
         2'b10: if (credits_q != CRED_W'(RS_DEPTH)) credits_d = credits_q + CRED_W'(1);
         2'b01: credits_d = credits_q - CRED_W'(1);
         default: credits_d = credits_q;
      endcase
      if (accept) begin
         tag_d         = next_tag(tag_q);
         pkt_d.opcode  = opcode;
         pkt_d.pc      = PC;
         pkt_d.rd_tag  = tag_q;
         pkt_d.op1_tag = src1_tag;
         pkt_d.op2_tag = src2_tag;
         pkt_d.op1_dat = src1_dat;
         pkt_d.op2_dat = src2_dat;
         pkt_d.valid   = {src2_vld, src1_vld};
      end
   end

   // Dispatch state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         credits_q <= CRED_W'(RS_DEPTH);
         tag_q     <= TAG_FIRST;
         disp_q    <= 1'b0;
         pkt_q     <= '0;
      end else begin
         credits_q <= credits_d;
         tag_q     <= tag_d;
         disp_q    <= disp_d;
         pkt_q     <= pkt_d;
      end
   end

   // Patch a waiting operand with a broadcast landing in the strobe cycle, which the RS would miss.
   always_comb begin
      pkt_out = pkt_q;
      if (disp_q && ALU_result_valid) begin
         if (!pkt_q.valid[0] && (pkt_q.op1_tag == ALU_result_dest)) begin
            pkt_out.valid[0] = 1'b1;
            pkt_out.op1_dat  = ALU_result;
         end
         if (!pkt_q.valid[1] && (pkt_q.op2_tag == ALU_result_dest)) begin
            pkt_out.valid[1] = 1'b1;
            pkt_out.op2_dat  = ALU_result;
         end
      end
   end

   assign rs_dispatch      = disp_q;
   assign rs_opcode        = pkt_out.opcode;
   assign rs_PC            = pkt_out.pc;
   assign rs_Rd            = pkt_out.rd_tag;
   assign rs_operand1      = pkt_out.op1_tag;
   assign rs_operand2      = pkt_out.op2_tag;
   assign rs_operand1_data = pkt_out.op1_dat;
   assign rs_operand2_data = pkt_out.op2_dat;
   assign rs_valid         = pkt_out.valid;

endmodule
